axi_lite_reg_slave: RTL and testbench
=====================================

// Module: axi_lite_reg_slave
// PURPOSE
//  AXI4-lite slave responder: the register-side end of the PCI target's tgt_m_* AXI4-lite master port.
//  Serialises AXI4-lite reads/writes onto a simple request/acknowledge register bus (reg_*) for NIC CSR blocks.
//  Bounded-wait timeout: a missing register ack still completes the AXI transaction, so the PCI target never hangs.
// PARAMETERS
//  ADDR_VALID_BITS  24   low address bits passed to reg_addr; upper bits forced to 0
//  TIMEOUT_CYCLES   256  cycles a register strobe is held without reg_ack before forced completion (>=2)
//  ERR_RDATA        32'hFFFFFFFF  rdata returned on read timeout (PCI master-abort value)
// PORTS
//  aclk      in   1   clock; all logic on rising edge
//  areset    in   1   asynchronous, active-high reset
//  axi_s_awvalid/awready  in/out  1   write address handshake
//  axi_s_awaddr   in   32  write byte address
//  axi_s_wvalid/wready    in/out  1   write data handshake
//  axi_s_wdata    in   32  write data
//  axi_s_wstrb    in   4   byte enables
//  axi_s_bvalid/bready    out/in  1   write response handshake
//  axi_s_bresp    out  2   2'b00 OKAY, 2'b10 SLVERR (timeout)
//  axi_s_arvalid/arready  in/out  1   read address handshake
//  axi_s_araddr   in   32  read byte address
//  axi_s_rvalid/rready    out/in  1   read data handshake
//  axi_s_rdata    out  32  read data
//  axi_s_rresp    out  2   2'b00 OKAY, 2'b10 SLVERR (timeout)
//  reg_addr   out  32  {0, addr[ADDR_VALID_BITS-1:2], 2'b00}; held stable while reg_wr/reg_rd high
//  reg_wr     out  1   write strobe, level, held until reg_ack or timeout
//  reg_rd     out  1   read strobe, level, held until reg_ack or timeout
//  reg_wdata  out  32  write data, valid with reg_wr
//  reg_wstrb  out  4   byte enables, valid with reg_wr
//  reg_rdata  in   32  read data, sampled in the reg_ack cycle
//  reg_ack    in   1   completion; may be combinational from strobe (0-wait) or later
// BEHAVIOUR
//  Reset: all ready/valid/strobe outputs 0; bresp/rresp 0; rdata 0; holding flags clear; FSM IDLE; last_grant=RD.
//  Capture: AW, W, AR each have a one-entry holding reg + full flag; awready=!aw_full, wready=!w_full,
//   arready=!ar_full (registered); AW and W accepted independently, in either order or the same cycle.
//  FSM: IDLE -> WR_REQ when aw_full&w_full and (!ar_full or last_grant==RD); IDLE -> RD_REQ when ar_full
//   and (!(aw_full&w_full) or last_grant==WR). Alternating priority when both pending; last_grant updated on grant.
//  WR_REQ: reg_wr=1; on reg_ack -> WR_RESP, bresp=OKAY; on timeout -> WR_RESP, bresp=SLVERR. Strobe drops same edge.
//  RD_REQ: reg_rd=1; on reg_ack latch reg_rdata, rresp=OKAY; on timeout rdata=ERR_RDATA, rresp=SLVERR -> RD_RESP.
//  WR_RESP: bvalid=1 until bready; on handshake clear aw_full,w_full -> IDLE. RD_RESP: same with rvalid/rready, ar_full.
//  Latency (0-wait ack, ready held): AW+W accepted cycle 0, reg_wr cycle 2 (after IDLE decides in cycle 1), bvalid cycle 3.
//  Timeout: counter cleared on REQ entry, increments each REQ cycle; timeout when count==TIMEOUT_CYCLES-1 without ack.
//  Ack arriving in the timeout cycle wins (OKAY). reg_ack outside REQ states ignored.
//  bvalid/rvalid never drop before handshake; at most one reg_* transaction outstanding; no new capture into a full slot.
//  areset mid-transaction: strobes and valids drop asynchronously; pending captured requests discarded.
// STRUCTURE
//  Shared package nic_axi_pkg: AXI_RESP_OKAY/SLVERR/DECERR constants, FSM state encoding typedef.
//  Sub-module axi_lite_hold_slot (one-entry valid/ready holding register), instantiated for AW, W, AR.
// TESTING
//  Write 0-wait: AW 0x000010 + W 0xA5A5A5A5 strb 0xF same cycle, reg_ack tied to reg_wr -> reg_wr cycle 2 with addr 0x10, bvalid cycle 3 bresp 00.
//  Split write: W first, AW 5 cycles later; bready low 4 cycles -> single reg_wr pulse, bvalid held stable until bready.
//  Read 3-wait: AR 0x000024, reg_ack 3 cycles after reg_rd with rdata 0x12345678 -> rdata 0x12345678 rresp 00, reg_rd high 4 cycles.
//  Timeout: read with reg_ack never asserted -> reg_rd drops after TIMEOUT_CYCLES, rdata 0xFFFFFFFF rresp 10; write likewise bresp 10.
//  Contention: write and read pending every cycle for 8 transactions -> grants alternate WR,RD,WR,...; address 0xFF000040 -> reg_addr 0x40.
//  Reset mid-REQ: assert areset during reg_rd -> reg_rd, rvalid, all readies 0 immediately; after release, next read completes normally.

Source files
------------

// File: rtl/nic_axi_pkg.sv
// Shared AXI4-lite response codes and register-slave FSM encoding.
// Imported by the holding slot and the register slave.
package nic_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_REQ  = 3'd1;
  localparam state_t ST_WR_RESP = 3'd2;
  localparam state_t ST_RD_REQ  = 3'd3;
  localparam state_t ST_RD_RESP = 3'd4;

endpackage

// File: rtl/axi_lite_hold_slot.sv
// One-entry valid/ready holding register for an AXI4-lite channel.
// Ports: clk, rst, valid/ready/data (upstream), clear, full, q (held payload).
module axi_lite_hold_slot
  import nic_axi_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [W-1:0] data,
  input  logic         clear,
  output logic         ready,
  output logic         full,
  output logic [W-1:0] q
);

  logic full_nxt;

  // ready is a flop tracking !full so it is 0 in reset
  // and never combinationally depends on valid.
  always_comb begin
    full_nxt = full;
    if (clear)
      full_nxt = 1'b0;
    else if (valid && ready)
      full_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      ready <= 1'b0;
      q     <= '0;
    end else begin
      if (valid && ready)
        q <= data;
      full  <= full_nxt;
      ready <= !full_nxt;
    end
  end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-lite slave that serialises reads/writes onto a req/ack register bus.
// Ports: aclk, areset, axi_s_* (AW/W/B/AR/R), reg_* (addr/wr/rd/wdata/wstrb/rdata/ack).
module axi_lite_reg_slave
  import nic_axi_pkg::*;
#(
  parameter int          ADDR_VALID_BITS = 24,
  parameter int          TIMEOUT_CYCLES  = 256,
  parameter logic [31:0] ERR_RDATA       = 32'hFFFF_FFFF
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        axi_s_awvalid,
  output logic        axi_s_awready,
  input  logic [31:0] axi_s_awaddr,
  input  logic        axi_s_wvalid,
  output logic        axi_s_wready,
  input  logic [31:0] axi_s_wdata,
  input  logic [3:0]  axi_s_wstrb,
  output logic        axi_s_bvalid,
  input  logic        axi_s_bready,
  output logic [1:0]  axi_s_bresp,
  input  logic        axi_s_arvalid,
  output logic        axi_s_arready,
  input  logic [31:0] axi_s_araddr,
  output logic        axi_s_rvalid,
  input  logic        axi_s_rready,
  output logic [31:0] axi_s_rdata,
  output logic [1:0]  axi_s_rresp,
  output logic [31:0] reg_addr,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_wstrb,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);

  // Keep addr[ADDR_VALID_BITS-1:2], zero the rest (word aligned).
  localparam logic [63:0] LOW_M = (64'd1 << ADDR_VALID_BITS) - 64'd1;
  localparam logic [31:0] AMASK = LOW_M[31:0] & 32'hFFFF_FFFC;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_rd;

  logic          aw_full, w_full, ar_full;
  logic [31:0]   aw_q, ar_q;
  logic [35:0]   w_q;
  logic          wr_clr, rd_clr;
  logic          wr_pend, rd_pend;

  assign wr_clr  = (state == ST_WR_RESP) && axi_s_bready;
  assign rd_clr  = (state == ST_RD_RESP) && axi_s_rready;
  assign wr_pend = aw_full && w_full;
  assign rd_pend = ar_full;

  axi_lite_hold_slot #(.W(32)) u_aw (
    .clk   (aclk),
    .rst   (areset),
    .valid (axi_s_awvalid),
    .data  (axi_s_awaddr),
    .clear (wr_clr),
    .ready (axi_s_awready),
    .full  (aw_full),
    .q     (aw_q)
  );

  axi_lite_hold_slot #(.W(36)) u_w (
    .clk   (aclk),
    .rst   (areset),
    .valid (axi_s_wvalid),
    .data  ({axi_s_wstrb, axi_s_wdata}),
    .clear (wr_clr),
    .ready (axi_s_wready),
    .full  (w_full),
    .q     (w_q)
  );

  axi_lite_hold_slot #(.W(32)) u_ar (
    .clk   (aclk),
    .rst   (areset),
    .valid (axi_s_arvalid),
    .data  (axi_s_araddr),
    .clear (rd_clr),
    .ready (axi_s_arready),
    .full  (ar_full),
    .q     (ar_q)
  );

  // Strobes/valids decode straight from the state flop so an
  // asynchronous reset removes them immediately.
  assign reg_wr       = (state == ST_WR_REQ);
  assign reg_rd       = (state == ST_RD_REQ);
  assign axi_s_bvalid = (state == ST_WR_RESP);
  assign axi_s_rvalid = (state == ST_RD_RESP);
  assign reg_wdata    = w_q[31:0];
  assign reg_wstrb    = w_q[35:32];
  assign reg_addr     = (state == ST_RD_REQ) ? (ar_q & AMASK)
                                             : (aw_q & AMASK);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      last_rd     <= 1'b1;
      axi_s_bresp <= AXI_RESP_OKAY;
      axi_s_rresp <= AXI_RESP_OKAY;
      axi_s_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // Alternate when both are pending; otherwise take whichever is.
          if (wr_pend && (!rd_pend || last_rd)) begin
            state   <= ST_WR_REQ;
            last_rd <= 1'b0;
          end else if (rd_pend) begin
            state   <= ST_RD_REQ;
            last_rd <= 1'b1;
          end
        end
        ST_WR_REQ: begin
          if (reg_ack) begin
            state       <= ST_WR_RESP;
            axi_s_bresp <= AXI_RESP_OKAY;
          end else if (cnt == TMAX) begin
            state       <= ST_WR_RESP;
            axi_s_bresp <= AXI_RESP_SLVERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RD_REQ: begin
          if (reg_ack) begin
            state       <= ST_RD_RESP;
            axi_s_rdata <= reg_rdata;
            axi_s_rresp <= AXI_RESP_OKAY;
          end else if (cnt == TMAX) begin
            state       <= ST_RD_RESP;
            axi_s_rdata <= ERR_RDATA;
            axi_s_rresp <= AXI_RESP_SLVERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (axi_s_bready)
            state <= ST_IDLE;
        end
        ST_RD_RESP: begin
          if (axi_s_rready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave with a programmable
// register-side responder (ack delay or no ack).
module tb_axi_lite_reg_slave;

  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        areset;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] reg_addr;
  logic        reg_wr, reg_rd;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ack_dly;
  logic        ack_never;
  logic [7:0]  hi_cnt;

  int          wr_cyc = 0;
  int          rd_cyc = 0;
  int          ngr = 0;
  logic [15:0] gseq = '0;
  logic [31:0] l_waddr = '0;
  logic [31:0] l_raddr = '0;
  logic [31:0] l_wdata = '0;
  logic [3:0]  l_wstrb = '0;
  logic        wr_d = 1'b0;
  logic        rd_d = 1'b0;

  always #5 aclk = ~aclk;

  axi_lite_reg_slave #(
    .ADDR_VALID_BITS (24),
    .TIMEOUT_CYCLES  (TO),
    .ERR_RDATA       (32'hFFFF_FFFF)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .axi_s_awvalid (awvalid),
    .axi_s_awready (awready),
    .axi_s_awaddr  (awaddr),
    .axi_s_wvalid  (wvalid),
    .axi_s_wready  (wready),
    .axi_s_wdata   (wdata),
    .axi_s_wstrb   (wstrb),
    .axi_s_bvalid  (bvalid),
    .axi_s_bready  (bready),
    .axi_s_bresp   (bresp),
    .axi_s_arvalid (arvalid),
    .axi_s_arready (arready),
    .axi_s_araddr  (araddr),
    .axi_s_rvalid  (rvalid),
    .axi_s_rready  (rready),
    .axi_s_rdata   (rdata),
    .axi_s_rresp   (rresp),
    .reg_addr      (reg_addr),
    .reg_wr        (reg_wr),
    .reg_rd        (reg_rd),
    .reg_wdata     (reg_wdata),
    .reg_wstrb     (reg_wstrb),
    .reg_rdata     (reg_rdata),
    .reg_ack       (reg_ack)
  );

  // Responder: ack after ack_dly extra strobe cycles (0 = same cycle).
  always @(posedge aclk) begin
    if (reg_wr || reg_rd)
      hi_cnt <= hi_cnt + 8'd1;
    else
      hi_cnt <= 8'd0;
  end

  assign reg_ack = (reg_wr || reg_rd) && !ack_never && (hi_cnt == ack_dly);

  // Free-running monitor; tests look at differences.
  always @(negedge aclk) begin
    if (reg_wr) begin
      wr_cyc  <= wr_cyc + 1;
      l_waddr <= reg_addr;
      l_wdata <= reg_wdata;
      l_wstrb <= reg_wstrb;
    end
    if (reg_rd) begin
      rd_cyc  <= rd_cyc + 1;
      l_raddr <= reg_addr;
    end
    if ((reg_wr && !wr_d) || (reg_rd && !rd_d)) begin
      gseq <= {gseq[14:0], reg_rd};
      ngr  <= ngr + 1;
    end
    wr_d <= reg_wr;
    rd_d <= reg_rd;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic wait_b(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bvalid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_r(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rvalid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step();
    step();
    areset = 1'b0;
    step();
    step();
  endtask

  bit ok;
  int w0, r0, n0;

  initial begin
    areset    = 1'b1;
    awvalid   = 0; awaddr = '0;
    wvalid    = 0; wdata  = '0; wstrb = '0;
    arvalid   = 0; araddr = '0;
    bready    = 1; rready = 1;
    reg_rdata = '0;
    ack_dly   = 8'd0;
    ack_never = 1'b0;
    hi_cnt    = 8'd0;
    step();
    step();
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_strobes", {reg_wr, reg_rd}, 0);
    chk("rst_rdata", rdata, 0);
    areset = 1'b0;
    step();
    step();

    // 0-wait write, cycle-accurate
    awvalid = 1; awaddr = 32'h0000_0010;
    wvalid  = 1; wdata  = 32'hA5A5_A5A5; wstrb = 4'hF;
    chk("w0_ready", {awready, wready}, 2'b11);
    step();
    awvalid = 0; wvalid = 0;
    chk("w0_c1_wr", reg_wr, 0);
    step();
    chk("w0_c2_wr", reg_wr, 1);
    chk("w0_c2_addr", reg_addr, 32'h10);
    chk("w0_c2_data", reg_wdata, 32'hA5A5_A5A5);
    chk("w0_c2_strb", reg_wstrb, 4'hF);
    step();
    chk("w0_c3_bvalid", bvalid, 1);
    chk("w0_c3_bresp", bresp, 2'b00);
    chk("w0_c3_wr", reg_wr, 0);
    step();
    chk("w0_c4_bvalid", bvalid, 0);

    // split write, W first, AW 5 cycles later, bready held low
    w0 = wr_cyc;
    n0 = ngr;
    bready = 0;
    wvalid = 1; wdata = 32'h1122_3344; wstrb = 4'h3;
    step();
    wvalid = 0;
    repeat (4) step();
    awvalid = 1; awaddr = 32'h0000_0008;
    chk("sw_nowr_early", wr_cyc - w0, 0);
    step();
    awvalid = 0;
    wait_b(ok);
    chk("sw_bwait", ok, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sw_bhold", {bvalid, bresp}, 3'b100);
    end
    chk("sw_pulses", ngr - n0, 1);
    chk("sw_wrcyc", wr_cyc - w0, 1);
    chk("sw_wdata", l_wdata, 32'h1122_3344);
    chk("sw_wstrb", l_wstrb, 4'h3);
    chk("sw_waddr", l_waddr, 32'h8);
    bready = 1;
    step();
    chk("sw_bdone", bvalid, 0);

    // read with 3 wait cycles
    r0 = rd_cyc;
    ack_dly = 8'd3;
    reg_rdata = 32'h1234_5678;
    arvalid = 1; araddr = 32'h0000_0024;
    step();
    arvalid = 0;
    wait_r(ok);
    chk("r3_rwait", ok, 1);
    chk("r3_rdata", rdata, 32'h1234_5678);
    chk("r3_rresp", rresp, 2'b00);
    chk("r3_rdcyc", rd_cyc - r0, 4);
    chk("r3_raddr", l_raddr, 32'h24);
    step();
    chk("r3_rdone", rvalid, 0);

    // read timeout
    ack_never = 1;
    r0 = rd_cyc;
    arvalid = 1; araddr = 32'h0000_0030;
    step();
    arvalid = 0;
    wait_r(ok);
    chk("to_rwait", ok, 1);
    chk("to_rdcyc", rd_cyc - r0, TO);
    chk("to_rdata", rdata, 32'hFFFF_FFFF);
    chk("to_rresp", rresp, 2'b10);
    step();

    // write timeout
    w0 = wr_cyc;
    awvalid = 1; awaddr = 32'h0000_0034;
    wvalid  = 1; wdata  = 32'h0BAD_0BAD; wstrb = 4'hF;
    step();
    awvalid = 0; wvalid = 0;
    wait_b(ok);
    chk("to_bwait", ok, 1);
    chk("to_wrcyc", wr_cyc - w0, TO);
    chk("to_bresp", bresp, 2'b10);
    step();
    ack_never = 0;

    // contention: both pending from the first decision after reset
    ack_dly = 8'd0;
    do_reset();
    n0 = ngr;
    awvalid = 1; awaddr = 32'hFF00_0040;
    wvalid  = 1; wdata  = 32'h5555_AAAA; wstrb = 4'hF;
    arvalid = 1; araddr = 32'h0000_0080;
    for (int i = 0; i < 200; i++) begin
      if (ngr - n0 >= 8) break;
      step();
    end
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("ct_grants", (ngr - n0 >= 8), 1);
    chk("ct_order", gseq[7:0], 8'b0101_0101);
    chk("ct_waddr", l_waddr, 32'h40);
    chk("ct_raddr", l_raddr, 32'h80);
    repeat (20) step();

    // reset in the middle of a read strobe
    ack_never = 1;
    arvalid = 1; araddr = 32'h0000_0044;
    step();
    arvalid = 0;
    step();
    chk("mr_rd_on", reg_rd, 1);
    areset = 1;
    #1;
    chk("mr_rd_off", reg_rd, 0);
    chk("mr_rvalid", rvalid, 0);
    chk("mr_readies", {awready, wready, arready}, 3'b000);
    step();
    areset = 0;
    ack_never = 0;
    ack_dly = 8'd1;
    reg_rdata = 32'hCAFE_F00D;
    step();
    step();
    chk("mr_rvalid_idle", rvalid, 0);
    arvalid = 1; araddr = 32'h0000_0048;
    step();
    arvalid = 0;
    wait_r(ok);
    chk("mr_rwait", ok, 1);
    chk("mr_rdata", rdata, 32'hCAFE_F00D);
    chk("mr_rresp", rresp, 2'b00);
    chk("mr_raddr", l_raddr, 32'h48);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
